// File: rtl/enc_lane_scheduler.sv
// Symbol-boundary scheduler: arbitrates OS generator vs transport layer per 1/8/16-byte symbol.
// Optional fairness limiter on OS priority is compiled in with `define ENC_SCHED_FAIR_EN.
module enc_lane_scheduler #(
  parameter logic [3:0] TL_DSEL    = 4'd8,
  parameter logic [3:0] IDLE_DSEL  = 4'd9,
  parameter int         FAIR_LIMIT = 4
) (
  input  logic       enc_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] gen_speed,
  input  logic       os_req,
  input  logic [3:0] os_sel,
  input  logic [7:0] os_lane_0,
  input  logic [7:0] os_lane_1,
  input  logic       tl_req,
  input  logic [7:0] tl_lane_0,
  input  logic [7:0] tl_lane_1,
  output logic       os_ready,
  output logic       tl_ready,
  output logic [7:0] lane_0_tx,
  output logic [7:0] lane_1_tx,
  output logic [3:0] d_sel,
  output logic       enc_enable,
  output logic       sym_start,
  output logic [3:0] byte_cnt
);

  typedef enum logic [1:0] {IDLE, OS, TL} state_t;

  state_t     state, grant;
  logic [3:0] cnt, cnt_nxt, last_idx;
  logic [3:0] dsel_reg, dsel_cur;
  logic [1:0] spd_reg, spd_cur;
  logic [7:0] lane0_nxt, lane1_nxt;
  logic       boundary;
  logic       force_tl;

  assign boundary = (cnt == 4'd0);

`ifdef ENC_SCHED_FAIR_EN
  logic [7:0] fair_cnt;

  // Counts OS symbols that were granted while TL was waiting.
  assign force_tl = tl_req && (fair_cnt == 8'(FAIR_LIMIT));

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      fair_cnt <= 8'd0;
    end else if (!enable) begin
      fair_cnt <= 8'd0;
    end else if (boundary) begin
      if (grant == OS) begin
        if (tl_req) fair_cnt <= fair_cnt + 8'd1;
      end else begin
        fair_cnt <= 8'd0;
      end
    end
  end
`else
  assign force_tl = 1'b0;
`endif

  always_comb begin
    spd_cur = boundary ? gen_speed : spd_reg;
    case (spd_cur)
      2'd1:    last_idx = 4'd15;
      2'd2:    last_idx = 4'd7;
      default: last_idx = 4'd0;
    endcase
    grant    = state;
    dsel_cur = dsel_reg;
    if (!enable) begin
      grant    = IDLE;
      dsel_cur = IDLE_DSEL;
    end else if (boundary) begin
      if (spd_cur == 2'd3) begin
        grant    = IDLE;
        dsel_cur = IDLE_DSEL;
      end else if (os_req && !force_tl) begin
        grant    = OS;
        dsel_cur = os_sel;
      end else if (tl_req) begin
        grant    = TL;
        dsel_cur = TL_DSEL;
      end else begin
        grant    = IDLE;
        dsel_cur = IDLE_DSEL;
      end
    end
    os_ready  = (grant == OS);
    tl_ready  = (grant == TL);
    // A granted source that drops req mid-symbol is padded with zeros.
    lane0_nxt = 8'd0;
    lane1_nxt = 8'd0;
    if (grant == OS && os_req) begin
      lane0_nxt = os_lane_0;
      lane1_nxt = os_lane_1;
    end else if (grant == TL && tl_req) begin
      lane0_nxt = tl_lane_0;
      lane1_nxt = tl_lane_1;
    end
    cnt_nxt = (cnt == last_idx) ? 4'd0 : cnt + 4'd1;
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst || !enable) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      spd_reg    <= 2'd0;
      dsel_reg   <= IDLE_DSEL;
      lane_0_tx  <= 8'd0;
      lane_1_tx  <= 8'd0;
      d_sel      <= IDLE_DSEL;
      enc_enable <= 1'b0;
      sym_start  <= 1'b0;
      byte_cnt   <= 4'd0;
    end else begin
      state      <= grant;
      cnt        <= cnt_nxt;
      dsel_reg   <= dsel_cur;
      if (boundary) spd_reg <= gen_speed;
      lane_0_tx  <= lane0_nxt;
      lane_1_tx  <= lane1_nxt;
      d_sel      <= dsel_cur;
      enc_enable <= (gen_speed != 2'd3);
      sym_start  <= boundary;
      byte_cnt   <= cnt;
    end
  end

endmodule
